pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum wait cycles for a data-memory access before an error is flagged; legal range 1..65535.
REQ-002 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 Port id_rs1, input, 5: rs1 index of the instruction in ID.
REQ-005 Port id_rs2, input, 5: rs2 index of the instruction in ID.
REQ-006 Port ex_mem_read, input, 1: the instruction in EX is a load.
REQ-007 Port ex_rd, input, 5: destination register index of the instruction in EX.
REQ-008 Port ex_br_taken, input, 1: a branch or jump in EX resolved taken.
REQ-009 Port dmem_req, input, 1: the MM stage has started or is holding a data-memory access.
REQ-010 Port dmem_ack, input, 1: data memory completes the access this cycle.
REQ-011 Port stall_if, output, 1: hold the PC register.
REQ-012 Port stall_id, output, 1: hold the IF/ID register.
REQ-013 Port stall_ex, output, 1: hold the ID/EX register.
REQ-014 Port stall_mm, output, 1: hold the EX/MM register; the MM/WB register receives a bubble.
REQ-015 Port flush_id, output, 1: load a bubble into IF/ID.
REQ-016 Port flush_ex, output, 1: load a bubble into ID/EX.
REQ-017 Port timeout_err, output, 1: sticky flag indicating a data-memory timeout.
REQ-018 Port stall_cycles, output, 32: performance counter; present only with HAZARD_PERF_CNT_EN.

Function
REQ-019 State machine states: RUN, MEM_WAIT, ERR; a 16-bit wait counter runs alongside it. All outputs are combinational functions of the state and the current inputs.
REQ-020 RUN, with dmem_req=1 and dmem_ack=0: stall_if, stall_id, stall_ex and stall_mm assert in that same cycle; the next state is MEM_WAIT and the wait counter loads 1.
REQ-021 RUN, with dmem_req=1 and dmem_ack=1: no stall; the FSM stays in RUN (single-cycle access).
REQ-022 MEM_WAIT, with dmem_ack=0: all four stalls assert, flush_id=flush_ex=0, and the wait counter increments.
REQ-023 MEM_WAIT, with dmem_ack=1: all stalls deassert in that cycle and the next state is RUN; ex_br_taken and load-use are evaluated normally in this cycle.
REQ-024 MEM_WAIT: when the wait counter equals TIMEOUT_CYCLES and dmem_ack=0, the next state is ERR. An ack arriving in that same cycle wins and returns the FSM to RUN.
REQ-025 ERR: all four stalls are held at 1, both flushes are 0, and timeout_err=1; ERR is left only by reset.
REQ-026 Branch in RUN, no memory stall: ex_br_taken=1 drives flush_id=1 and flush_ex=1 for that cycle; no stall is asserted.
REQ-027 Load-use in RUN, no memory stall and no branch: ex_mem_read=1, ex_rd!=0, and ex_rd equals id_rs1 or id_rs2. Response for one cycle: stall_if=1, stall_id=1, flush_ex=1, stall_ex=0, stall_mm=0.
REQ-028 Priority order: memory wait or ERR, then branch flush, then load-use. When branch and load-use coincide, only the branch response is produced.
REQ-029 ex_rd=0 never raises a load-use stall.
REQ-030 A stall output and a flush output for the same register never assert together.

Reset
REQ-031 While rst_n=0: state=RUN, wait counter=0, timeout_err=0, stall_cycles=0. Every output is 0 when inputs are 0.
REQ-032 Reset asserted in MEM_WAIT or ERR forces RUN immediately; all stalls drop without waiting for a clock edge.
REQ-033 Following reset deassertion, the first rising edge evaluates inputs normally.

Configuration
REQ-034 Macro HAZARD_PERF_CNT_EN defined: stall_cycles is a 32-bit saturating counter that increments on every clock edge where stall_if=1.
REQ-035 Macro HAZARD_PERF_CNT_EN undefined: the stall_cycles port and its counter are absent; all other behaviour is unchanged.

Verification
REQ-036 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 for one cycle -> that cycle stall_if=stall_id=flush_ex=1, stall_ex=0; all outputs 0 on the following cycle once ex_mem_read=0.
REQ-037 Branch plus load-use in the same cycle: ex_br_taken=1 with the hazard of REQ-036 -> flush_id=flush_ex=1, stall_if=0.
REQ-038 Memory wait: dmem_req=1 with dmem_ack low for 3 cycles, then high -> four stalls for 3 cycles; 0 in the ack cycle; state RUN afterwards.
REQ-039 Timeout, TIMEOUT_CYCLES=4: dmem_req=1 and no ack -> ERR after the 4th wait-count cycle; timeout_err=1 held through 20 further cycles with an ack applied.
REQ-040 Reset mid-wait: rst_n low during MEM_WAIT -> stalls 0 before the next edge; with HAZARD_PERF_CNT_EN, stall_cycles=0.
REQ-041 Performance counter: with HAZARD_PERF_CNT_EN, 3 wait cycles plus 1 load-use cycle -> stall_cycles=4.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush control for a five-stage in-order pipeline.
// It resolves data-memory waits (with a timeout that sticks in an error
// state), taken-branch flushes and load-use hazards, in that priority.
// Outputs are combinational in the state and the current inputs, so a
// hazard is answered in the cycle it appears.
// Optional feature: define HAZARD_PERF_CNT_EN to add the stall_cycles
// performance counter (a saturating count of cycles with stall_if high).
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_br_taken,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mm,
  output logic        flush_id,
  output logic        flush_ex,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cycles,
`endif
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        mem_stall_s;
  logic        load_use_s;

  // Load-use: the load in EX writes a register the instruction in ID reads;
  // x0 is never a real dependency.
  always_comb begin
    load_use_s = ex_mem_read && (ex_rd != 5'd0) &&
                 ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

  // Next-state and wait-counter logic for the data-memory wait FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_stall_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (dmem_req && !dmem_ack) begin
          mem_stall_s = 1'b1;
          state_d     = ST_MEM_WAIT;
          cnt_d       = 16'd1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        // An ack in the timeout cycle still wins and returns to RUN.
        if (dmem_ack) begin
          state_d = ST_RUN;
          cnt_d   = 16'd0;
        end else if (cnt_q == TIMEOUT_L) begin
          mem_stall_s = 1'b1;
          state_d     = ST_ERR;
        end else begin
          mem_stall_s = 1'b1;
          cnt_d       = cnt_q + 16'd1;
        end
      end
      ST_ERR: begin
        // Only reset leaves ERR; the pipeline stays frozen.
        mem_stall_s = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Output decode in priority order: memory wait/error, branch, load-use.
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mm    = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    timeout_err = (state_q == ST_ERR);
    if (mem_stall_s) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
      stall_mm = 1'b1;
    end else if (ex_br_taken) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (load_use_s) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end else begin
      stall_if = 1'b0;
    end
  end

  // FSM state and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    if (stall_if && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Performance counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard sequences with
// literal expectations, then randomized traffic compared every cycle
// against a behavioural model (access age / error flag / stall count).
// Honours HAZARD_PERF_CNT_EN the same way as the design.
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;

  logic        clk, rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_mem_read, ex_br_taken, dmem_req, dmem_ack;
  logic        stall_if, stall_id, stall_ex, stall_mm, flush_id, flush_ex, timeout_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mm(stall_mm),
    .flush_id(flush_id), .flush_ex(flush_ex),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall_if, stall_id, stall_ex, stall_mm, flush_id, flush_ex, timeout_err}
  logic [6:0] got_s;
  assign got_s = {stall_if, stall_id, stall_ex, stall_mm, flush_id, flush_ex, timeout_err};

  // Behavioural model: age of the pending memory access (0 = none),
  // sticky error flag, and count of PC-hold cycles.
  int          m_age;
  bit          m_err;
  logic [31:0] m_perf;
  logic [6:0]  exp_s;

  function automatic logic [6:0] model_out();
    bit hold;
    bit lu;
    hold = m_err || (!dmem_ack && ((m_age > 0) || dmem_req));
    lu   = ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    if (hold)             return {4'b1111, 2'b00, m_err};
    else if (ex_br_taken) return 7'b0000110;
    else if (lu)          return 7'b1100010;
    else                  return 7'b0000000;
  endfunction

  always_comb exp_s = model_out();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age  <= 0;
      m_err  <= 1'b0;
      m_perf <= 32'd0;
    end else begin
      if (exp_s[6] && (m_perf != 32'hFFFF_FFFF)) m_perf <= m_perf + 32'd1;
      if (!m_err) begin
        if (m_age > 0) begin
          if (dmem_ack)         m_age <= 0;
          else if (m_age == TO) m_err <= 1'b1;
          else                  m_age <= m_age + 1;
        end else if (dmem_req && !dmem_ack) begin
          m_age <= 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (got_s !== exp_s) begin
        failures++;
        $display("FAIL model_cmp t=%0t got=%b exp=%b", $time, got_s, exp_s);
      end
      checks++;
      if ((stall_id && flush_id) || (stall_ex && flush_ex)) begin
        failures++;
        $display("FAIL stall_flush_excl t=%0t got=%b exp=no stall+flush on one register", $time, got_s);
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (stall_cycles !== m_perf) begin
        failures++;
        $display("FAIL perf_cmp t=%0t got=%0d exp=%0d", $time, stall_cycles, m_perf);
      end
`endif
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic mr,
                        input logic [4:0] rd, input logic br, input logic req, input logic ack);
    id_rs1 = rs1; id_rs2 = rs2; ex_mem_read = mr; ex_rd = rd;
    ex_br_taken = br; dmem_req = req; dmem_ack = ack;
  endtask

  // Check outputs mid-cycle against a literal, then move to the next drive point.
  task automatic cyc_chk(input string nm, input logic [6:0] exp);
    @(negedge clk);
    chk(nm, {25'd0, got_s}, {25'd0, exp});
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk(nm, {25'd0, got_s}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk({nm, "_perf"}, stall_cycles, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("reset_outputs", {25'd0, got_s}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Load-use on rs2, then clear.
    set_in(5'd0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); cyc_chk("load_use", 7'b1100010);
    set_in(5'd0, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0); cyc_chk("load_use_after", 7'b0000000);
    // Branch wins over load-use.
    set_in(5'd0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); cyc_chk("br_plus_lu", 7'b0000110);
    // x0 destination never stalls.
    set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); cyc_chk("rd_zero", 7'b0000000);
    set_in(5'd3, 5'd9, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0); cyc_chk("load_use_rs1", 7'b1100010);
    // Single-cycle memory access.
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); cyc_chk("mem_1cyc", 7'b0000000);

    // Reset in the middle of a wait.
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); cyc_chk("pre_rst_wait0", 7'b1111000);
    cyc_chk("pre_rst_wait1", 7'b1111000);
    do_reset("rst_mid_wait");

    // Three wait cycles (branch ignored during wait), ack, then a load-use.
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); cyc_chk("mem_wait0", 7'b1111000);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); cyc_chk("mem_wait1_br", 7'b1111000);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); cyc_chk("mem_wait2", 7'b1111000);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); cyc_chk("mem_ack", 7'b0000000);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); cyc_chk("mem_run_after", 7'b0000000);
    set_in(5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); cyc_chk("load_use_perf", 7'b1100010);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk);
    chk("perf_count4", stall_cycles, 32'd4);
    @(posedge clk); #1;
`endif

    // Timeout: one RUN stall cycle plus TO wait-count cycles, then ERR.
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i <= TO; i++) cyc_chk("timeout_pre", 7'b1111000);
    cyc_chk("timeout_err_set", 7'b1111001);
    set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cyc_chk("timeout_sticky", 7'b1111001);
    do_reset("rst_from_err");

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ((i % 100) == 99) begin
        do_reset("rand_rst");
      end else begin
        id_rs1      = 5'($urandom_range(0, 3));
        id_rs2      = 5'($urandom_range(0, 3));
        ex_rd       = 5'($urandom_range(0, 3));
        ex_mem_read = ($urandom_range(0, 1) == 1);
        ex_br_taken = ($urandom_range(0, 4) == 0);
        dmem_req    = ($urandom_range(0, 2) == 0);
        dmem_ack    = ($urandom_range(0, 99) < (((i / 100) % 3) * 35 + 10));
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
